// File: rtl/mem_bus_port_pkg.sv
// Shared types and constants for the LC-3 memory bus port and its helpers.
package mem_bus_port_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  localparam int   DATA_W_DEFAULT = 16;
  localparam logic RW_READ        = 1'b0;
  localparam logic RW_WRITE       = 1'b1;

endpackage

// File: rtl/mem_bus_port_wait_ctr.sv
// mem_wait_ctr: loadable down-counter for wait-stated peripherals.
// Load wins over enable; the count stops at zero and flags it.
module mem_wait_ctr #(
  parameter int W = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         zero
);

  // count register: load takes priority, otherwise decrement toward zero
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                cnt <= '0;
    else if (load)            cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_bus_port.sv
// mem_bus_port: memory-side consumer of the LC-3 data bus.
// Holds MAR/MDR, runs single-word SRAM accesses with a fixed wait count and
// pulses ready on completion. Optional macro MEM_PORT_ERR_EN enables a sticky
// err flag for loads/requests issued while busy.
module mem_bus_port
  import mem_bus_port_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              mem_req,
  input  logic              mem_rw,
  output logic [DATA_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic              busy,
  output logic              ready,
  output logic [DATA_W-1:0] ADDR,
  output logic [DATA_W-1:0] Data_to_SRAM,
  input  logic [DATA_W-1:0] Data_from_SRAM,
  output logic              CE_N,
  output logic              OE_N,
  output logic              WE_N,
  output logic              err
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  mem_state_t  state, state_nxt;
  logic        accept;
  logic        rw_q;
  logic [3:0]  cnt;
  logic        cnt_zero;

  mem_wait_ctr #(.W(4)) u_wait_ctr (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (accept),
    .load_val (WAIT_INIT),
    .en       (state == ACCESS),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state decode; accept only from IDLE so requests while busy are dropped
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          accept    = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  if (cnt_zero) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // MAR/MDR: bus loads only in IDLE; read data lands on the last ACCESS edge
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      MAR <= '0;
      MDR <= '0;
    end else if (state == IDLE) begin
      if (LD_MAR) MAR <= bus_in;
      if (LD_MDR) MDR <= bus_in;
    end else if (state == ACCESS && cnt_zero && rw_q == RW_READ) begin
      MDR <= Data_from_SRAM;
    end
  end

  // access latch; bypasses bus_in so a same-cycle load feeds the request
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ADDR         <= '0;
      Data_to_SRAM <= '0;
      rw_q         <= RW_READ;
    end else if (accept) begin
      ADDR         <= LD_MAR ? bus_in : MAR;
      Data_to_SRAM <= LD_MDR ? bus_in : MDR;
      rw_q         <= mem_rw;
    end
  end

  // strobes and handshakes decoded purely from registers (glitch-free)
  assign busy  = (state != IDLE);
  assign ready = (state == DONE);
  assign CE_N  = ~(state == ACCESS);
  assign OE_N  = ~(state == ACCESS && rw_q == RW_READ);
  assign WE_N  = ~(state == ACCESS && rw_q == RW_WRITE);

`ifdef MEM_PORT_ERR_EN
  // sticky protocol error: any load or request attempted while busy
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                                    err <= 1'b0;
    else if (busy && (LD_MAR || LD_MDR || mem_req)) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
